// File: rtl/seq_divider_param.sv
// Self-sequenced restoring divider (unsigned / two's complement) with start/busy/done
// handshake, explicit divide-by-zero and signed-overflow flags.
module seq_divider_param #(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             dbz,
    output logic             ovf
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    typedef enum logic [1:0] {K_NORM, K_DBZ, K_OVF} kind_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + ONE) : v;
    endfunction

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] dq_q, dq_d;      // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             qsgn_q, qsgn_d;
    logic             rsgn_q, rsgn_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] shl;
    logic [WIDTH+1:0] trial;
    logic             a_neg, b_neg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            kind_q  <= K_NORM;
            cnt_q   <= '0;
            acc_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            araw_q  <= '0;
            qsgn_q  <= 1'b0;
            rsgn_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            araw_q  <= araw_d;
            qsgn_q  <= qsgn_d;
            rsgn_q  <= rsgn_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // One extra bit on the trial keeps its sign unambiguous for any divisor magnitude.
    assign shl   = {acc_q, dq_q[WIDTH-1]};
    assign trial = shl - {2'b00, dvs_q};
    assign a_neg = signed_mode & a_in[WIDTH-1];
    assign b_neg = signed_mode & b_in[WIDTH-1];

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        araw_d  = araw_q;
        qsgn_d  = qsgn_q;
        rsgn_d  = rsgn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dq_d   = neg_if(a_in, a_neg);
                    dvs_d  = neg_if(b_in, b_neg);
                    qsgn_d = a_neg ^ b_neg;
                    rsgn_d = a_neg;
                    araw_d = a_in;
                    acc_d  = '0;
                    cnt_d  = CNT_W'(WIDTH-1);
                    if (b_in == '0) begin
                        kind_d  = K_DBZ;
                        state_d = S_FIX;
                    end else if (signed_mode && a_in == MIN_NEG && b_in == '1) begin
                        kind_d  = K_OVF;
                        state_d = S_FIX;
                    end else begin
                        kind_d  = K_NORM;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = trial[WIDTH+1] ? shl[WIDTH:0] : trial[WIDTH:0];
                dq_d  = {dq_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == S_FIX) begin
            done_d = 1'b1;
            case (kind_q)
                K_DBZ: begin
                    q_out_d = '1;
                    r_out_d = araw_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                end
                K_OVF: begin
                    q_out_d = MIN_NEG;
                    r_out_d = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                end
                default: begin
                    q_out_d = neg_if(dq_q, qsgn_q);
                    r_out_d = neg_if(acc_q[WIDTH-1:0], rsgn_q);
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign q_out = q_out_q;
    assign r_out = r_out_q;
    assign dbz   = dbz_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
Parametrised, self-sequenced restoring divider with an integrated controller. It replaces the split datapath/controller divider pair with a single block that accepts operands on a start/busy/done handshake. It returns quotient and remainder and supports unsigned and signed (two's complement) modes. Divide-by-zero and signed-overflow are flagged explicitly. It sits as the divide unit beside the existing arithmetic blocks.

Parameters:
WIDTH, 10, operand/quotient/remainder width in bits (legal range 4..32)
CNT_W, $clog2(WIDTH), width of the internal iteration counter

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a_in  input  WIDTH  dividend; sampled with start
b_in  input  WIDTH  divisor; sampled with start
busy  output  1  high from the edge after start acceptance until done
done  output  1  one-cycle pulse; results valid from this cycle onward
q_out  output  WIDTH  quotient, held until the next done
r_out  output  WIDTH  remainder, held until the next done
dbz  output  1  divide-by-zero flag for the last operation
ovf  output  1  signed overflow flag for the last operation

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, busy=0, done=0, q_out=0, r_out=0, dbz=0, ovf=0, counter=0, internal registers cleared. Takes effect immediately, including mid-operation; the aborted operation produces no done.
- States: IDLE, CALC, FIX.
- IDLE: start=1 at an edge accepts the operands.
  - Latch the magnitudes of a_in and b_in. Signed inputs are negated if their MSB is 1; unsigned inputs pass through.
  - Latch the quotient sign (a MSB xor b MSB) and the remainder sign (a MSB). Both signs are 0 in unsigned mode.
  - Clear the (WIDTH+1)-bit accumulator and load counter=WIDTH-1.
  - If b_in==0, go to FIX with the dbz condition. Otherwise, if signed_mode and a_in=100..0 and b_in=all ones, go to FIX with the ovf condition. Otherwise go to CALC.
  - busy=1 from this edge onward.
- CALC: one restoring step per cycle.
  - Shift {acc, dividend} left by 1.
  - Trial value = acc - divisor at WIDTH+1 bits.
  - If the trial value is non-negative, acc = trial value and the quotient bit is 1. Otherwise acc is kept and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the quotient register. The counter decrements.
  - After the step with counter==0, go to FIX. CALC lasts exactly WIDTH cycles.
- FIX: one cycle, then go to IDLE. At this edge q_out, r_out, dbz and ovf update, done=1 and busy=0.
  - Normal result: q_out = quotient, negated if the quotient sign is 1. r_out = acc[WIDTH-1:0], negated if the remainder sign is 1. dbz=0, ovf=0.
  - dbz result: q_out = all ones, r_out = a_in as latched (original, not magnitude), dbz=1, ovf=0.
  - ovf result: q_out = 100..0, r_out = 0, ovf=1, dbz=0.
- Latency, start edge to done-high:
  - Normal: WIDTH+1 cycles.
  - dbz/ovf: 1 cycle.
- done is high for exactly one cycle. It clears at the next edge unless another completion occurs at that edge.
- start while busy=1 is ignored; the operands are not resampled.
- start=1 in the cycle done=1 is accepted (state is IDLE), giving back-to-back operation. The results stay held until that operation's FIX.
- Invariants for a normal result: a = q*b + r. |r| < |b|. r has the sign of a or is zero (truncating division).
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit accumulator. No combinational path from the inputs to any output.

Test Plan:
- Unsigned, WIDTH=10: a_in=1000, b_in=7, start 1 cycle -> busy high 11 cycles, done at start+11, q_out=142, r_out=6, dbz=0, ovf=0.
- Signed: a_in=-100 (0x39C), b_in=7 -> q_out=0x3F2 (-14), r_out=0x3FE (-2). Then a_in=100, b_in=-7 -> q_out=-14, r_out=+2.
- Divide by zero: a_in=55, b_in=0 (either mode) -> done at start+1, dbz=1, q_out=0x3FF, r_out=55.
- Signed overflow: a_in=0x200, b_in=0x3FF, signed_mode=1 -> done at start+1, ovf=1, q_out=0x200, r_out=0. The same operands unsigned -> q_out=0, r_out=512, ovf=0.
- Handshake:
  - Pulse start with new operands mid-CALC -> ignored; the first result stands.
  - Assert start in the done cycle with a_in=1023, b_in=1023 -> second done 11 cycles later, q_out=1, r_out=0.
- Reset mid-op: drive clr=0 for 3 cycles during CALC -> immediately busy=0, q_out=r_out=0, no done. A subsequent 9/3 returns q_out=3, r_out=0.
